// File: rtl/sop_pkg.sv
// Shared types and helpers for the sum-of-products / Horner engine.
package sop_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic MODE_SOP    = 1'b0;
   localparam logic MODE_HORNER = 1'b1;

   // Number of MAC steps a job takes for the given mode and operand count.
   function automatic int calc_k(input logic mode, input int n_ops);
      return (mode == MODE_HORNER) ? (n_ops - 2) : ((n_ops + 1) / 2);
   endfunction

endpackage

// File: rtl/sop_mac.sv
// Accumulator with shared multiply-add, sticky overflow and optional clamp.
// SOP_SATURATE_EN: clamp on first overflow and freeze for the rest of the job.
module sop_mac
   import sop_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_step,
   input  logic         i_mode,
   input  logic [W-1:0] i_init,
   input  logic [W-1:0] i_opa,
   input  logic [W-1:0] i_opb,
   output logic [W-1:0] o_acc_nxt,
   output logic         o_ovf
);

   localparam int PW = 2*W + 1;

   logic [W-1:0]  r_acc;
   logic          r_ovf;
   logic [PW-1:0] w_mul_x;
   logic [PW-1:0] w_mul_y;
   logic [PW-1:0] w_add;
   logic [PW-1:0] w_true;
   logic          w_step_ovf;
   logic          w_ovf_nxt;
`ifdef SOP_SATURATE_EN
   logic          r_sat;
`endif

   // SOP: acc + a*b.  Horner: acc*x + coefficient.
   always_comb begin
      w_mul_x    = (i_mode == MODE_HORNER) ? PW'(r_acc) : PW'(i_opa);
      w_mul_y    = (i_mode == MODE_HORNER) ? PW'(i_opa) : PW'(i_opb);
      w_add      = (i_mode == MODE_HORNER) ? PW'(i_opb) : PW'(r_acc);
      w_true     = w_mul_x * w_mul_y + w_add;
      w_step_ovf = |w_true[PW-1:W];
`ifdef SOP_SATURATE_EN
      o_acc_nxt  = r_sat ? r_acc : (w_step_ovf ? {W{1'b1}} : w_true[W-1:0]);
      w_ovf_nxt  = r_ovf | (w_step_ovf & ~r_sat);
`else
      o_acc_nxt  = w_true[W-1:0];
      w_ovf_nxt  = r_ovf | w_step_ovf;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
`ifdef SOP_SATURATE_EN
         r_sat <= 1'b0;
`endif
      end else if (i_load) begin
         r_acc <= i_init;
         r_ovf <= 1'b0;
`ifdef SOP_SATURATE_EN
         r_sat <= 1'b0;
`endif
      end else if (i_step) begin
         r_acc <= o_acc_nxt;
         r_ovf <= w_ovf_nxt;
`ifdef SOP_SATURATE_EN
         r_sat <= r_sat | w_step_ovf;
`endif
      end
   end

   assign o_ovf = r_ovf;

endmodule

// File: rtl/sop_engine.sv
// Start/done evaluator: latches N_OPS operands, runs K MAC steps, pulses done.
// SOP_SATURATE_EN (in sop_mac) selects clamping instead of wrapping on overflow.
module sop_engine
   import sop_pkg::*;
#(
   parameter int W     = 32,
   parameter int N_OPS = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [N_OPS*W-1:0] ops,
   output logic [W-1:0]       result,
   output logic               done,
   output logic               busy,
   output logic               ovf
);

   localparam int CW = $clog2(N_OPS) + 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic               r_mode;
   logic [N_OPS*W-1:0] r_ops;
   logic [W-1:0]       r_result;
   logic               w_load;
   logic               w_step;
   logic               w_last;
   logic [W-1:0]       w_init;
   logic [W-1:0]       w_opa;
   logic [W-1:0]       w_opb;
   logic [W-1:0]       w_acc_nxt;

   assign w_last = (int'(r_cnt) == calc_k(r_mode, N_OPS) - 1);
   assign w_init = (mode == MODE_HORNER) ? ops[W +: W] : '0;

   // Operand select; an odd SOP tail pairs the last operand with 1.
   always_comb begin
      w_opa = '0;
      w_opb = '0;
      if (r_mode == MODE_HORNER) begin
         w_opa = r_ops[0 +: W];
         for (int i = 2; i < N_OPS; i++)
            if (i == int'(r_cnt) + 2) w_opb = r_ops[i*W +: W];
      end else begin
         w_opb = W'(1);
         for (int i = 0; i < N_OPS; i++) begin
            if (i == 2*int'(r_cnt))     w_opa = r_ops[i*W +: W];
            if (i == 2*int'(r_cnt) + 1) w_opb = r_ops[i*W +: W];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = CALC;
               w_load      = 1'b1;
            end
         end
         CALC: begin
            w_step = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_mode   <= MODE_SOP;
         r_ops    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_cnt  <= '0;
            r_mode <= mode;
            r_ops  <= ops;
         end
         if (w_step) r_cnt <= r_cnt + CW'(1);
         if (w_step && w_last) r_result <= w_acc_nxt;
      end
   end

   sop_mac #(.W(W)) u_mac (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_mode    (r_mode),
      .i_init    (w_init),
      .i_opa     (w_opa),
      .i_opb     (w_opb),
      .o_acc_nxt (w_acc_nxt),
      .o_ovf     (ovf)
   );

   assign result = r_result;
   assign done   = (r_state == DONE);
   assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_sop_engine.sv
// Randomised and directed bench for sop_engine against a job-level reference model.
module tb_sop_engine;
   import sop_pkg::*;

   localparam int W = 32;
   localparam int N = 7;

   typedef logic [W-1:0] opv_t [N];

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           mode = 1'b0;
   logic [N*W-1:0] ops = '0;
   logic [W-1:0]   result;
   logic           done;
   logic           busy;
   logic           ovf;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   sop_engine #(.W(W), .N_OPS(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .ops    (ops),
      .result (result),
      .done   (done),
      .busy   (busy),
      .ovf    (ovf)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] pack(input opv_t o);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = o[i];
      return v;
   endfunction

   function automatic opv_t unpack(input logic [N*W-1:0] v);
      opv_t o;
      for (int i = 0; i < N; i++) o[i] = v[i*W +: W];
      return o;
   endfunction

   // Whole-job reference: evaluates the expression directly from the operand list.
   function automatic void model(input logic md, input opv_t o,
                                 output logic [W-1:0] r, output logic v);
      logic [2*W:0] t;
      logic [W-1:0] acc;
      logic [W-1:0] b;
      bit           sat;
      v   = 1'b0;
      sat = 1'b0;
      if (md == MODE_SOP) begin
         acc = '0;
         for (int k = 0; k < N; k += 2) begin
            b = (k + 1 < N) ? o[k+1] : 32'd1;
            t = {{(W+1){1'b0}}, acc} + {{(W+1){1'b0}}, o[k]} * {{(W+1){1'b0}}, b};
            if (!sat) begin
               if (t[2*W:W] != 0) begin
                  v = 1'b1;
`ifdef SOP_SATURATE_EN
                  sat = 1'b1;
                  acc = '1;
`else
                  acc = t[W-1:0];
`endif
               end else acc = t[W-1:0];
            end
         end
      end else begin
         acc = o[1];
         for (int k = 2; k < N; k++) begin
            t = {{(W+1){1'b0}}, acc} * {{(W+1){1'b0}}, o[0]} + {{(W+1){1'b0}}, o[k]};
            if (!sat) begin
               if (t[2*W:W] != 0) begin
                  v = 1'b1;
`ifdef SOP_SATURATE_EN
                  sat = 1'b1;
                  acc = '1;
`else
                  acc = t[W-1:0];
`endif
               end else acc = t[W-1:0];
            end
         end
      end
      r = acc;
   endfunction

   // Cycle-level expectation: a countdown of K steps per accepted job.
   logic         m_busy = 0, m_done = 0, m_ovf = 0;
   logic [W-1:0] m_res = '0, p_res;
   logic         p_ovf;
   int           m_rem = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_ovf = 0; m_res = '0; m_rem = 0;
      end else if (m_done) begin
         m_done = 0;
         m_busy = 0;
      end else if (m_busy) begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1;
            m_res  = p_res;
            m_ovf  = p_ovf;
         end
      end else if (start) begin
         m_busy = 1;
         m_rem  = calc_k(mode, N);
         m_ovf  = 0;
         model(mode, unpack(ops), p_res, p_ovf);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("done", done, m_done);
         check("busy", busy, m_busy);
         if (!(m_busy && !m_done)) begin
            check("result", result, m_res);
            check("ovf", ovf, m_ovf);
         end
      end
   end

   // Call at +2 after an edge; the next edge samples start.
   task automatic drive_start(input logic md, input logic [N*W-1:0] o);
      start = 1'b1;
      mode  = md;
      ops   = o;
      @(posedge clk);
      #2 start = 1'b0;
   endtask

   // Waits for done, checks latency/result/ovf, then confirms done is one cycle wide.
   task automatic wait_done(input string name, input int exp_lat,
                            input logic [W-1:0] exp_res, input logic exp_ovf);
      int cyc  = 0;
      bit seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) seen = 1;
      end
      check({name, " latency"}, cyc, exp_lat);
      check({name, " result"}, result, exp_res);
      check({name, " ovf"}, ovf, exp_ovf);
      @(posedge clk);
      #1;
      check({name, " done width"}, done, 1'b0);
      check({name, " busy after"}, busy, 1'b0);
      #1;
   endtask

   opv_t           base_o, ov_o, rnd_o;
   logic [N*W-1:0] base_v, ov_v, alt_v;
   logic [W-1:0]   mr;
   logic           mv;
   int             dn;

   initial begin
      base_o = '{32'd2, 32'd3, 32'd4, 32'd2, 32'd5, 32'd2, 32'd10};
      ov_o   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};
      base_v = pack(base_o);
      ov_v   = pack(ov_o);
      alt_v  = pack('{32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9});

      // Pin the reference model with hand-computed values.
      model(MODE_SOP, base_o, mr, mv);
      check("model sop", {mv, mr}, {1'b0, 32'd34});
      model(MODE_HORNER, base_o, mr, mv);
      check("model horner", {mv, mr}, {1'b0, 32'd210});
      model(MODE_SOP, ov_o, mr, mv);
`ifdef SOP_SATURATE_EN
      check("model ovf", {mv, mr}, {1'b1, 32'hFFFF_FFFF});
`else
      check("model ovf", {mv, mr}, {1'b1, 32'h0000_0001});
`endif

      @(posedge clk);
      #2 chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset result", result, 0);
      check("reset done", done, 0);
      check("reset busy", busy, 0);
      check("reset ovf", ovf, 0);
      #1 rst = 1'b0;

      drive_start(MODE_SOP, base_v);
      wait_done("sop", 4, 32'd34, 1'b0);
      drive_start(MODE_HORNER, base_v);
      wait_done("horner", 5, 32'd210, 1'b0);

      drive_start(MODE_SOP, ov_v);
`ifdef SOP_SATURATE_EN
      wait_done("ovf sop", 4, 32'hFFFF_FFFF, 1'b1);
`else
      wait_done("ovf sop", 4, 32'h0000_0001, 1'b1);
`endif

      // Re-pulse start one cycle into CALC with different inputs.
      drive_start(MODE_SOP, base_v);
      start = 1'b1; mode = MODE_HORNER; ops = alt_v;
      @(posedge clk);
      #2 start = 1'b0;
      wait_done("restart ignored", 3, 32'd34, 1'b0);
      dn = 0;
      repeat (8) begin @(posedge clk); #1; if (done) dn++; end
      check("no second done", dn, 0);
      #1;

      // Reset two cycles into CALC.
      drive_start(MODE_SOP, base_v);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort result", result, 0);
      check("abort done", done, 0);
      check("abort busy", busy, 0);
      check("abort ovf", ovf, 0);
      #1 rst = 1'b0;
      dn = 0;
      repeat (6) begin @(posedge clk); #1; if (done) dn++; end
      check("abort no done", dn, 0);
      #1;
      drive_start(MODE_SOP, base_v);
      wait_done("after abort", 4, 32'd34, 1'b0);

      // Back-to-back: wait_done returns in the first IDLE cycle after DONE.
      drive_start(MODE_SOP, base_v);
      wait_done("b2b sop", 4, 32'd34, 1'b0);
      drive_start(MODE_HORNER, base_v);
      wait_done("b2b horner", 5, 32'd210, 1'b0);

      // Random traffic: start pulses, mid-job restarts, occasional reset.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++)
            rnd_o[i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 20);
         ops   = pack(rnd_o);
         mode  = $urandom_range(0, 1) == 1;
         start = $urandom_range(0, 2) == 0;
         rst   = $urandom_range(0, 99) == 0;
      end
      @(posedge clk);
      #2 start = 1'b0; rst = 1'b0;
      repeat (10) @(posedge clk);
      #2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
